// File: rtl/dflop_chk_pkg.sv
// Shared types and the reference next-state function for the enabled,
// synchronously cleared D flip-flop response checker.
package dflop_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } chk_state_e;

  localparam int CNT_W_DEFAULT = 16;
  localparam int WARM_W        = 4;

  function automatic logic dflop_model_next(input logic cur, input logic d,
                                            input logic en, input logic clr_n);
    return !clr_n ? 1'b0 : (en ? d : cur);
  endfunction

endpackage

// File: rtl/dflop_en_clr_checker_sat_counter.sv
// Saturating up-counter; a clear together with an increment yields 1 so a
// same-edge event is never lost by a clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_value != '1)) begin
      r_value <= r_value + W'(1);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/dflop_en_clr_checker.sv
// In-circuit shadow-model checker for the enabled/cleared D flop.
// Define DFLOP_CHK_STOP_ON_ERR_EN to stop counting in FAIL after the first mismatch.
//
// state | meaning
// IDLE  | model tracks the flop output, no compares, status held
// ARM   | model free-runs, compares masked for WARMUP cycles
// CHECK | model free-runs, every cycle counted and compared
// FAIL  | stop-on-error only: counters frozen, model still runs
module dflop_en_clr_checker
  import dflop_chk_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int WARMUP = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             obs_in_1,
  input  logic             obs_enable,
  input  logic             obs_clear_n,
  input  logic             obs_out_1,
  input  logic             check_en,
  input  logic             err_clr,
  output logic             mismatch,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [1:0]       state
);

  chk_state_e        r_state;
  chk_state_e        w_state_nxt;
  logic              exp_q;
  logic              r_mismatch;
  logic              r_error;
  logic [CNT_W-1:0]  r_first_err;
  logic [WARM_W-1:0] w_warm_elapsed;
  logic              w_arm_start;
  logic              w_in_check;
  logic              w_cmp_hit;
  logic              w_first_hit;
  logic              w_warm_done;
  logic              w_model_cur;
  logic              w_model_next;

  assign w_arm_start  = (r_state == IDLE) && check_en;
  assign w_in_check   = (r_state == CHECK) && check_en;
  assign w_cmp_hit    = w_in_check && (obs_out_1 != exp_q);
  assign w_first_hit  = w_cmp_hit && (!r_error || err_clr);
  assign w_warm_done  = (w_warm_elapsed == WARM_W'(WARMUP - 1));
  // IDLE re-seeds the model from the real flop so arming never starts stale.
  assign w_model_cur  = (r_state == IDLE) ? obs_out_1 : exp_q;
  assign w_model_next = dflop_model_next(w_model_cur, obs_in_1, obs_enable, obs_clear_n);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (check_en) w_state_nxt = ARM;
      ARM: begin
        if (!check_en)        w_state_nxt = IDLE;
        else if (w_warm_done) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (!check_en)      w_state_nxt = IDLE;
`ifdef DFLOP_CHK_STOP_ON_ERR_EN
        else if (w_cmp_hit) w_state_nxt = FAIL;
`endif
      end
      FAIL: begin
        if (!check_en)    w_state_nxt = IDLE;
        else if (err_clr) w_state_nxt = CHECK;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      exp_q       <= 1'b0;
      r_mismatch  <= 1'b0;
      r_error     <= 1'b0;
      r_first_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      exp_q      <= w_model_next;
      r_mismatch <= w_cmp_hit;
      // A mismatch on the same edge as a clear takes priority.
      if (w_cmp_hit)                    r_error <= 1'b1;
      else if (w_arm_start || err_clr)  r_error <= 1'b0;
      if (w_first_hit)                  r_first_err <= cycle_count;
      else if (w_arm_start || err_clr)  r_first_err <= '0;
    end
  end

  // Elapsed ARM cycles; remaining warm-up is WARMUP minus this value.
  sat_counter #(.W(WARM_W)) u_warm_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (r_state == ARM),
    .i_clr   (r_state == IDLE),
    .o_value (w_warm_elapsed)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_cmp_hit),
    .i_clr   (w_arm_start || err_clr),
    .o_value (err_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_in_check),
    .i_clr   (w_arm_start),
    .o_value (cycle_count)
  );

  assign mismatch        = r_mismatch;
  assign error           = r_error;
  assign first_err_cycle = r_first_err;
  assign state           = r_state;

endmodule

// File: tb/tb_dflop_en_clr_checker.sv
// Randomised self-checking bench for dflop_en_clr_checker against a behavioural
// reference; builds with or without DFLOP_CHK_STOP_ON_ERR_EN.
module tb_dflop_en_clr_checker;

  localparam int CW   = 6;
  localparam int WU   = 2;
  localparam int MAXV = (1 << CW) - 1;
`ifdef DFLOP_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          obs_in_1, obs_enable, obs_clear_n, obs_out_1;
  logic          check_en, err_clr;
  logic          mismatch, error;
  logic [CW-1:0] err_count, cycle_count, first_err_cycle;
  logic [1:0]    state;

  logic flop_q;
  logic inj;
  logic ignore_clr;

  int checks = 0;
  int errors = 0;

  // Reference model state (phase: 0 idle, 1 arming, 2 checking, 3 failed)
  int   m_state, m_arm_left, m_errcnt, m_cyc, m_first;
  logic m_exp, m_err, m_mis;
  logic mc_cur, mc_hit;

  always #50 clk = ~clk;

  assign obs_out_1 = flop_q ^ inj;

  dflop_en_clr_checker #(.CNT_W(CW), .WARMUP(WU)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .obs_in_1        (obs_in_1),
    .obs_enable      (obs_enable),
    .obs_clear_n     (obs_clear_n),
    .obs_out_1       (obs_out_1),
    .check_en        (check_en),
    .err_clr         (err_clr),
    .mismatch        (mismatch),
    .error           (error),
    .err_count       (err_count),
    .cycle_count     (cycle_count),
    .first_err_cycle (first_err_cycle),
    .state           (state)
  );

  // Flop under observation; ignore_clr plants a broken-clear fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       flop_q <= 1'b0;
    else if (!obs_clear_n && !ignore_clr) flop_q <= 1'b0;
    else if (obs_enable)                flop_q <= obs_in_1;
  end

  wire [3*CW+3:0] dut_vec = {mismatch, error, err_count, cycle_count, first_err_cycle, state};

  function automatic logic [3*CW+3:0] exp_vec();
    return {m_mis, m_err, CW'(m_errcnt), CW'(m_cyc), CW'(m_first), 2'(m_state)};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_state = 0; m_arm_left = 0; m_errcnt = 0; m_cyc = 0; m_first = 0;
        m_exp = 1'b0; m_err = 1'b0; m_mis = 1'b0;
      end else begin
        mc_hit = (m_state == 2) && check_en && (obs_out_1 != m_exp);
        mc_cur = (m_state == 0) ? obs_out_1 : m_exp;
        m_exp  = !obs_clear_n ? 1'b0 : (obs_enable ? obs_in_1 : mc_cur);
        m_mis  = mc_hit;
        if (err_clr) begin m_err = 1'b0; m_errcnt = 0; m_first = 0; end
        if (mc_hit) begin
          if (!m_err) begin m_first = m_cyc; m_err = 1'b1; end
          if (m_errcnt < MAXV) m_errcnt++;
        end
        case (m_state)
          0: if (check_en) begin
               m_state = 1; m_arm_left = WU;
               m_errcnt = 0; m_cyc = 0; m_first = 0; m_err = 1'b0;
             end
          1: if (!check_en) m_state = 0;
             else begin
               m_arm_left--;
               if (m_arm_left == 0) m_state = 2;
             end
          2: if (!check_en) m_state = 0;
             else begin
               if (m_cyc < MAXV) m_cyc++;
               if (STOP && mc_hit) m_state = 3;
             end
          default: if (!check_en) m_state = 0;
                   else if (err_clr) m_state = 2;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rearm();
    int n;
    inj = 1'b0; err_clr = 1'b0; check_en = 1'b0; obs_clear_n = 1'b1; ignore_clr = 1'b0;
    tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rearm_idle: actual %h required %h", dut_vec, exp_vec()); end
    check_en = 1'b1;
    n = 0;
    while (m_state != 2 && n < 10) begin tick(); n++; end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rearm_reach_check: actual %0d required 2", state); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; check_en = 1'b0; err_clr = 1'b0; inj = 1'b0; ignore_clr = 1'b0;
    obs_in_1 = 1'b0; obs_enable = 1'b0; obs_clear_n = 1'b1;
    repeat (2) tick();
    checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs: actual %h required 0", dut_vec); end
    reset_n = 1'b1;
    tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL idle_after_reset: actual %h required %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_toggle_clean();
    check_en = 1'b1; obs_clear_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      obs_in_1   = i[0];
      obs_enable = ((i % 3) != 2);
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL toggle_c%0d: actual %h required %h", i, dut_vec, exp_vec()); end
    end
    checks++; if (err_count !== '0 || error !== 1'b0) begin errors++; $display("FAIL toggle_clean: actual cnt=%0d err=%0b required 0/0", err_count, error); end
    checks++; if (cycle_count !== CW'(30 - 1 - WU)) begin errors++; $display("FAIL toggle_cycles: actual %0d required %0d", cycle_count, 30 - 1 - WU); end
  endtask

  task automatic test_inject();
    int n;
    check_en = 1'b0; obs_clear_n = 1'b0; obs_enable = 1'b0; inj = 1'b0;
    tick();
    check_en = 1'b1; obs_clear_n = 1'b1;
    n = 0;
    while (!(m_state == 2 && m_cyc == 5) && n < 20) begin
      tick(); n++;
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL inject_pre: actual %h required %h", dut_vec, exp_vec()); end
    end
    checks++; if (cycle_count !== CW'(5)) begin errors++; $display("FAIL inject_reach5: actual %0d required 5", cycle_count); end
    inj = 1'b1;
    tick();
    inj = 1'b0;
    checks++; if (mismatch !== 1'b1 || err_count !== CW'(1) || first_err_cycle !== CW'(5)) begin
      errors++; $display("FAIL inject_hit: actual mis=%0b cnt=%0d first=%0d required 1/1/5", mismatch, err_count, first_err_cycle); end
    tick();
    checks++; if (mismatch !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL inject_after: actual mis=%0b err=%0b required 0/1", mismatch, error); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL inject_vec: actual %h required %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_clear();
    rearm();
    obs_clear_n = 1'b0; obs_enable = 1'b1; obs_in_1 = 1'b1;
    repeat (2) begin
      tick();
      checks++; if (mismatch !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL clear_good: actual %h required %h", dut_vec, exp_vec()); end
    end
    ignore_clr = 1'b1;
    tick();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL clear_bad_lat: actual %0b required 0", mismatch); end
    tick();
    checks++; if (mismatch !== 1'b1 || err_count !== CW'(1)) begin errors++; $display("FAIL clear_bad_hit: actual mis=%0b cnt=%0d required 1/1", mismatch, err_count); end
    ignore_clr = 1'b0;
    repeat (2) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL clear_recover: actual %h required %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_collide();
    int exp_first;
    rearm();
    obs_clear_n = 1'b1; obs_enable = 1'b0;
    repeat (3) tick();
    inj = 1'b1; tick(); inj = 1'b0;
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL collide_first: actual %h required %h", dut_vec, exp_vec()); end
`ifdef DFLOP_CHK_STOP_ON_ERR_EN
    err_clr = 1'b1; tick(); err_clr = 1'b0;
`else
    tick();
    inj = 1'b1; tick(); inj = 1'b0;
`endif
    tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL collide_pre: actual %h required %h", dut_vec, exp_vec()); end
    exp_first = m_cyc;
    inj = 1'b1; err_clr = 1'b1;
    tick();
    inj = 1'b0; err_clr = 1'b0;
    checks++; if (err_count !== CW'(1) || error !== 1'b1 || first_err_cycle !== CW'(exp_first)) begin
      errors++; $display("FAIL collide: actual cnt=%0d err=%0b first=%0d required 1/1/%0d", err_count, error, first_err_cycle, exp_first); end
  endtask

  task automatic test_random();
    rearm();
    for (int i = 0; i < 80; i++) begin
      obs_in_1    = 1'($urandom_range(0, 1));
      obs_enable  = 1'($urandom_range(0, 1));
      obs_clear_n = ($urandom_range(0, 5) != 0);
      inj         = ($urandom_range(0, 7) == 0);
      err_clr     = ($urandom_range(0, 9) == 0);
      check_en    = ($urandom_range(0, 29) != 0);
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_c%0d: actual %h required %h", i, dut_vec, exp_vec()); end
    end
    inj = 1'b0; err_clr = 1'b0; check_en = 1'b1;
  endtask

  task automatic test_saturation();
    rearm();
    for (int i = 0; i < 70; i++) begin
      obs_in_1 = 1'($urandom_range(0, 1)); obs_enable = 1'($urandom_range(0, 1));
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sat_cycle_c%0d: actual %h required %h", i, dut_vec, exp_vec()); end
    end
    checks++; if (cycle_count !== CW'(MAXV)) begin errors++; $display("FAIL sat_cycle: actual %0d required %0d", cycle_count, MAXV); end
`ifndef DFLOP_CHK_STOP_ON_ERR_EN
    inj = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sat_err_c%0d: actual %h required %h", i, dut_vec, exp_vec()); end
    end
    inj = 1'b0;
    checks++; if (err_count !== CW'(MAXV) || cycle_count !== CW'(MAXV)) begin
      errors++; $display("FAIL sat_err: actual cnt=%0d cyc=%0d required %0d", err_count, cycle_count, MAXV); end
`endif
  endtask

  task automatic test_reset_mid();
    rearm();
    inj = 1'b1; tick(); inj = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    #20 reset_n = 1'b0;
    #1;
    checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_mid: actual %h required 0", dut_vec); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_mid_after: actual %h required %h", dut_vec, exp_vec()); end
  endtask

`ifdef DFLOP_CHK_STOP_ON_ERR_EN
  task automatic test_stop();
    int cyc0;
    rearm();
    obs_enable = 1'b0; obs_clear_n = 1'b1;
    repeat (2) tick();
    cyc0 = m_cyc;
    inj = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL stop_inj: actual %h required %h", dut_vec, exp_vec()); end
    end
    inj = 1'b0;
    checks++; if (state !== 2'd3 || err_count !== CW'(1) || cycle_count !== CW'(cyc0 + 1)) begin
      errors++; $display("FAIL stop_frozen: actual st=%0d cnt=%0d cyc=%0d required 3/1/%0d", state, err_count, cycle_count, cyc0 + 1); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL stop_clr_state: actual %0d required 2", state); end
    tick();
    checks++; if (cycle_count !== CW'(cyc0 + 2)) begin errors++; $display("FAIL stop_resume: actual %0d required %0d", cycle_count, cyc0 + 2); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_toggle_clean();
    test_inject();
    test_clear();
    test_collide();
    test_random();
    test_saturation();
    test_reset_mid();
`ifdef DFLOP_CHK_STOP_ON_ERR_EN
    test_stop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dflop_en_clr_checker.md
# dflop_en_clr_checker

In-circuit response checker for the enabled, synchronously cleared D flip-flop cell. It observes the cell's inputs and its `out_1` output, runs a cycle-accurate shadow model, and reports mismatches with a sticky flag, an error count and the cycle of the first failure. It sits beside the flop instance, on the same clock and reset, and is used in benches and bring-up builds as a hardware self-check.

## Interface
- `CNT_W`, default 16: width of the error, cycle and first-error counters.
- `WARMUP`, default 2: number of ARM cycles after arming during which compares are masked. Legal range is 1 to 15.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `obs_in_1` input 1: copy of the flop's `in_1`.
- `obs_enable` input 1: copy of the flop's `enable`.
- `obs_clear_n` input 1: copy of the flop's `clear_n`.
- `obs_out_1` input 1: the flop's `out_1`.
- `check_en` input 1: level; high arms and keeps the checker running.
- `err_clr` input 1: single-cycle pulse; clears the error status.
- `mismatch` output 1: registered pulse, high for one cycle per counted mismatch.
- `error` output 1: sticky error flag.
- `err_count` output CNT_W: number of mismatches; saturates at all-ones.
- `cycle_count` output CNT_W: number of CHECK cycles; saturates.
- `first_err_cycle` output CNT_W: value of `cycle_count` at the first mismatch.
- `state` output 2: current FSM state, encoded IDLE=0, ARM=1, CHECK=2, FAIL=3.

## Operation
- Model function: `next = !clear_n ? 0 : (enable ? in_1 : cur)`. The model is held in register `exp_q`.
- IDLE:
  - Model resyncs every cycle: `exp_q <= next` with `cur = obs_out_1`.
  - No compares. Counters and flags hold their values.
- IDLE -> ARM when `check_en` = 1. On that edge, clear `err_count`, `cycle_count`, `first_err_cycle` and `error`, and load the warm-up counter with `WARMUP`.
- ARM:
  - Model self-runs with `cur = exp_q`.
  - Compares are masked.
  - Warm-up counter decrements; move to CHECK on the edge where it reaches 0.
- CHECK:
  - Model self-runs.
  - Each edge, `cycle_count` increments.
  - If `obs_out_1 != exp_q` (sampled before the update): `mismatch` = 1 next cycle and `err_count` increments. On the first mismatch, `error` is set and `first_err_cycle` captures the pre-increment `cycle_count`.
- `check_en` = 0 in ARM, CHECK or FAIL: go to IDLE on the next edge. Counters and flags hold for readout.
- `err_clr`:
  - Clears `error`, `err_count` and `first_err_cycle` in any state.
  - If a mismatch occurs on the same edge, the mismatch wins: `err_count` = 1, `error` = 1, `first_err_cycle` = current cycle.
  - In FAIL, `err_clr` returns the FSM to CHECK.
- Saturation: counters stop at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: `state` = IDLE, `exp_q` = 0, all counters = 0, `error` = 0, `mismatch` = 0.
- Reset is honored immediately, including mid-CHECK. It does not wait for a clock edge.
- Compare latency: a mismatch present before edge N appears on `mismatch`/`err_count` after edge N, i.e. one cycle.
- The first compare happens on edge `WARMUP`+1 after the IDLE->ARM edge.
- The checker assumes the flop resets to 0 on the same `reset_n`.

## Configuration
- `DFLOP_CHK_STOP_ON_ERR_EN` defined:
  - The first counted mismatch moves CHECK to FAIL.
  - FAIL freezes `cycle_count` and `err_count` and masks compares.
  - The model keeps running.
  - FAIL exits to CHECK on `err_clr`, or to IDLE when `check_en` = 0.
- Not defined: the FAIL state is unreachable and CHECK counts every mismatch.

## Structure
- Shared package `dflop_chk_pkg` holds:
  - the state enum typedef (IDLE/ARM/CHECK/FAIL) and its 2-bit encoding;
  - `CNT_W_DEFAULT`;
  - a function `dflop_model_next(cur, d, en, clr_n)` giving the model function above.
- One natural sub-module, `sat_counter` (parameter width; inputs increment and clear; output value; saturating). It is instantiated three times.

## Test plan
1. Reset, then hold `check_en` = 1 with a correct flop and the toggle stimulus (`in_1` every 100 ns, `enable` every 150 ns, `clk` period 100 ns) -> `err_count` = 0, `error` = 0, `cycle_count` increments from `WARMUP` cycles after arming.
2. Force `obs_out_1` = 1 for one cycle while the model is 0, at CHECK cycle 5 -> one-cycle `mismatch` pulse, `err_count` = 1, `first_err_cycle` = 5, `error` stays 1 after the pulse.
3. `obs_clear_n` = 0 with `obs_enable` = 1 and `obs_in_1` = 1, flop correctly outputs 0 -> no mismatch. The same stimulus with a flop that ignores clear -> mismatch on the next edge.
4. Assert `err_clr` on the same edge as a new mismatch -> `err_count` = 1, `error` = 1, `first_err_cycle` = that cycle.
5. Assert `reset_n` low mid-CHECK between edges -> all outputs read 0 and `state` = 0 before the next edge.
6. With `DFLOP_CHK_STOP_ON_ERR_EN` defined, inject 3 consecutive mismatches -> `state` = 3, `err_count` = 1, `cycle_count` frozen. Then pulse `err_clr` -> `state` = 2 and counting resumes.
